fs_accel_linebuf: RTL

Raster-to-column line buffer for the accelerator's 3x3 convolution path. Accepts an 8-bit pixel stream in row-major order and holds the two previous image rows. For each pixel accepted from row 2 onward, it emits one vertically aligned 3-pixel column (top, middle, bottom). It sits directly upstream of the accelerator input register: `col_do_0..2` drive its data inputs, and `col_valid && col_ready` drives its load enable.

---
 rtl/fs_accel_pkg.sv | 14 +
 rtl/fs_accel_lbram.sv | 23 ++
 rtl/fs_accel_linebuf.sv | 128 ++++++++++++
 3 files changed

// File: rtl/fs_accel_pkg.sv
// Shared types and constants for the accelerator line-buffer path.
package fs_accel_pkg;

  localparam int unsigned PIX_W     = 8;
  localparam int unsigned IMG_W_DEF = 28;
  localparam int unsigned IMG_H_DEF = 28;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2
  } state_t;

endpackage

// File: rtl/fs_accel_lbram.sv
// Single-port line memory: combinational read at addr, registered write.
module fs_accel_lbram
  import fs_accel_pkg::*;
#(
  parameter int unsigned DEPTH = IMG_W_DEF,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [PIX_W-1:0] wdata,
  output logic [PIX_W-1:0] rdata
);

  logic [PIX_W-1:0] mem [DEPTH];

  always_comb rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/fs_accel_linebuf.sv
// Raster-to-column line buffer: holds two previous rows and emits
// vertically aligned 3-pixel columns for each pixel from row 2 onward.
module fs_accel_linebuf
  import fs_accel_pkg::*;
#(
  parameter int unsigned IMG_W = IMG_W_DEF,
  parameter int unsigned IMG_H = IMG_H_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_data,
  output logic             pix_ready,
  output logic [PIX_W-1:0] col_do_0,
  output logic [PIX_W-1:0] col_do_1,
  output logic [PIX_W-1:0] col_do_2,
  output logic             col_valid,
  input  logic             col_ready,
  output logic             col_eor,
  output logic             col_eof,
  output logic             busy,
  output logic             done
);

  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned ROW_W = $clog2(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  state_t           state, state_nxt;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             accept;
  logic             last_col;
  logic             last_row;
  logic             mem_we;
  logic [PIX_W-1:0] lb0_rd;
  logic [PIX_W-1:0] lb1_rd;

  always_comb begin
    pix_ready = (state != IDLE) && !start && (!col_valid || col_ready);
    accept    = pix_valid && pix_ready;
    last_col  = (col == COL_LAST);
    last_row  = (row == ROW_LAST);
    mem_we    = accept && resetn;
    busy      = (state != IDLE);
  end

  // lb0 holds row r-1, lb1 holds row r-2; lb1 takes lb0's old value
  fs_accel_lbram #(.DEPTH(IMG_W), .AW(COL_W)) lb0 (
    .clk   (clk),
    .we    (mem_we),
    .addr  (col),
    .wdata (pix_data),
    .rdata (lb0_rd)
  );

  fs_accel_lbram #(.DEPTH(IMG_W), .AW(COL_W)) lb1 (
    .clk   (clk),
    .we    (mem_we),
    .addr  (col),
    .wdata (lb0_rd),
    .rdata (lb1_rd)
  );

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = FILL;
    end else if (accept && last_col) begin
      case (state)
        FILL:    if (row == ROW_W'(1)) state_nxt = STREAM;
        STREAM:  if (last_row)         state_nxt = IDLE;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      col       <= '0;
      row       <= '0;
      col_do_0  <= '0;
      col_do_1  <= '0;
      col_do_2  <= '0;
      col_valid <= 1'b0;
      col_eor   <= 1'b0;
      col_eof   <= 1'b0;
      done      <= 1'b0;
    end else if (start) begin
      col       <= '0;
      row       <= '0;
      col_valid <= 1'b0;
      col_eor   <= 1'b0;
      col_eof   <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= accept && (state == STREAM) && last_col && last_row;
      if (accept) begin
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
      end
      if (accept && (state == STREAM)) begin
        col_do_0  <= lb1_rd;
        col_do_1  <= lb0_rd;
        col_do_2  <= pix_data;
        col_valid <= 1'b1;
        col_eor   <= last_col;
        col_eof   <= last_col && last_row;
      end else if (col_ready) begin
        col_valid <= 1'b0;
        col_eor   <= 1'b0;
        col_eof   <= 1'b0;
      end
    end
  end

endmodule
